alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational datapath ALU between NREQ requesters (e.g. execute stage, address generator, debug port) using a round-robin grant and valid/ready handshakes. The block registers the winner's operands onto the ALU input bus, captures the ALU result one cycle later, and returns it to the granted requester. It sits between the requesters and the ALU, and is the only driver of the ALU inputs.

## Interface

- NREQ, 2: number of requesters, 2..8.
- ID_W, 1: width of the grant index, clog2(NREQ), minimum 1.

- clk  in  1  system clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  one-hot; accept strobe for the granted requester.
- req_op  in  NREQ*3  ALU opcode per requester, packed with requester i at [3i+2:3i].
- req_immd_sel  in  NREQ  per-requester select of the immediate as source 1.
- req_reg1  in  NREQ*32  source 0 operand per requester.
- req_reg2  in  NREQ*32  source 1 register operand per requester.
- req_immd  in  NREQ*17  immediate per requester.
- alu_op / alu_immd_sel / alu_reg1 / alu_reg2 / alu_immd  out  3/1/32/32/17  registered drive of the ALU inputs.
- alu_data_out  in  32  ALU result.
- rsp_valid  out  NREQ  one-hot; result valid for the owning requester.
- rsp_data  out  32  registered result.
- rsp_ready  in  NREQ  per-requester result accept.
- busy  out  1  high in every state except IDLE.

## Operation

- The FSM has three states: IDLE, EXEC and RESP.
- **IDLE**
  - If any req_valid is high, pick the winner w: the first valid index at or after ptr, wrapping from NREQ-1 to 0.
  - Assert req_ready[w] combinationally in the same cycle.
  - On the edge, latch the winner's fields into the alu_* registers, store w in gnt_id, and go to EXEC.
- **EXEC**
  - Hold the alu_* registers stable.
  - On the edge, capture alu_data_out into rsp_data, then go to RESP.
- **RESP**
  - Hold rsp_valid[gnt_id] high; hold rsp_data and the alu_* registers stable.
  - On rsp_ready[gnt_id], set ptr to gnt_id+1 (wrapping to 0 after NREQ-1) and go to IDLE.
  - rsp_ready on any other index is ignored.
- **Handshake rules**
  - Requesters hold their valid and payload stable until they see ready.
  - The arbiter samples the payload only in the accept cycle.
  - A valid dropped before ready is simply not granted.
- rsp_ready asserted before rsp_valid has no effect.
- A requester may assert req_valid for its next operation while its own response is pending. It is considered again only in the next IDLE.
- The ALU is combinational. The arbiter does not interpret opcodes and passes all eight encodings through unchanged.
- **Reset**
  - Values: state=IDLE, ptr=0, gnt_id=0, all alu_* outputs=0 (opcode ADD), rsp_data=0, rsp_valid=0, req_ready=0, busy=0.
  - Reset asserted mid-operation discards the transaction; no response is ever produced for it.

## Timing

- Accept at cycle T (req_valid[w] & req_ready[w]).
- Operands are valid on alu_* from T+1 and stay stable through the response handshake.
- rsp_valid is high from T+2.
- If rsp_ready is high at T+2, the state is IDLE at T+3. The earliest next accept is T+3, so a full operation takes 3 cycles and throughput is at most one operation per 3 cycles.
- RESP stalls indefinitely with no timeout.
- req_ready is never high outside IDLE, and at most one bit of req_ready or rsp_valid is set at any time.

## Configuration

- ALU_ARB_PRIO_EN defined: requester 0 has strict priority whenever it is valid in IDLE. The remaining requesters are served round-robin among themselves, with ptr skipping index 0.
- Not defined: pure round-robin across all NREQ requesters as described above.

## Structure

- Shared package alu_arb_pkg holds:
  - the opcode localparams ADD=0, SUB=1, AND=2, OR=3, NOR=4, SLL=5, SRL=6, SRA=7;
  - the state enum IDLE/EXEC/RESP;
  - the ALU_W=32 and IMM_W=17 constants.
- One sub-module, alu_rr_pick:
  - inputs: valid vector and ptr;
  - outputs: one-hot grant and its index;
  - purely combinational.

## Test plan

- Single request: req 0 with ADD, reg1=5, reg2=7, immd_sel=0, accepted at T → rsp_valid[0]=1 and rsp_data=12 at T+2; busy=0 at T+3.
- Immediate path: req 1 with OR, reg1=0xF0, immd=0x0F, immd_sel=1 → alu_immd_sel=1 at T+1, rsp_data=0xFF.
- Contention: both requesters valid continuously with rsp_ready tied high → grants alternate 0,1,0,1, one accept every 3 cycles.
- With ALU_ARB_PRIO_EN: NREQ=3, all requesters valid continuously → req 0 granted every time while valid. With req 0 idle, grants alternate 1,2,1.
- Back-pressure: rsp_ready held low for 5 cycles → rsp_valid and rsp_data stable, no req_ready pulses, ptr unchanged until the handshake.
- Reset mid-operation: rst low during EXEC → all outputs return to their reset values immediately, no rsp_valid follows, and the first grant after release goes to req 0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared opcodes, FSM state type and datapath widths for the ALU arbiter.
package alu_arb_pkg;

   localparam int ALU_W = 32;
   localparam int IMM_W = 17;

   localparam logic [2:0] ADD = 3'd0;
   localparam logic [2:0] SUB = 3'd1;
   localparam logic [2:0] AND = 3'd2;
   localparam logic [2:0] OR  = 3'd3;
   localparam logic [2:0] NOR = 3'd4;
   localparam logic [2:0] SLL = 3'd5;
   localparam logic [2:0] SRL = 3'd6;
   localparam logic [2:0] SRA = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_rr_pick.sv
// alu_rr_pick: combinational round-robin picker, first valid index at or after i_ptr with wrap.
//   i_valid [NREQ]  candidate vector
//   i_ptr   [ID_W]  index with highest priority this round
//   o_gnt   [NREQ]  one-hot grant (all zero when nothing is valid)
//   o_idx   [ID_W]  index of the granted bit (0 when nothing is valid)
module alu_rr_pick #(
   parameter int NREQ = 2,
   parameter int ID_W = 1
) (
   input  logic [NREQ-1:0] i_valid,
   input  logic [ID_W-1:0] i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [ID_W-1:0] o_idx
);

   logic w_found;

   // First pass covers indices from ptr upward; second pass covers the wrap to
   // indices below ptr (anything at or above ptr would already have been found).
   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && i >= int'(i_ptr) && i_valid[i]) begin
            w_found  = 1'b1;
            o_gnt[i] = 1'b1;
            o_idx    = ID_W'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && i_valid[i]) begin
            w_found  = 1'b1;
            o_gnt[i] = 1'b1;
            o_idx    = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between NREQ requesters.
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req_valid/o_req_ready per-requester operation handshake (ready one-hot, IDLE only)
//   i_req_op/_immd_sel/_reg1/_reg2/_immd  packed per-requester payload, requester i at slice i
//   o_alu_op/_immd_sel/_reg1/_reg2/_immd  registered ALU input drive
//   i_alu_data_out          ALU result, captured during EXEC
//   o_rsp_valid/i_rsp_ready one-hot response handshake for the granted requester
//   o_rsp_data              registered result
//   o_busy                  high whenever the FSM is not IDLE
// Option: define ALU_ARB_PRIO_EN to give requester 0 strict priority, others round-robin.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int ID_W = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [NREQ-1:0]       i_req_valid,
   output logic [NREQ-1:0]       o_req_ready,
   input  logic [3*NREQ-1:0]     i_req_op,
   input  logic [NREQ-1:0]       i_req_immd_sel,
   input  logic [ALU_W*NREQ-1:0] i_req_reg1,
   input  logic [ALU_W*NREQ-1:0] i_req_reg2,
   input  logic [IMM_W*NREQ-1:0] i_req_immd,
   output logic [2:0]            o_alu_op,
   output logic                  o_alu_immd_sel,
   output logic [ALU_W-1:0]      o_alu_reg1,
   output logic [ALU_W-1:0]      o_alu_reg2,
   output logic [IMM_W-1:0]      o_alu_immd,
   input  logic [ALU_W-1:0]      i_alu_data_out,
   output logic [NREQ-1:0]       o_rsp_valid,
   output logic [ALU_W-1:0]      o_rsp_data,
   input  logic [NREQ-1:0]       i_rsp_ready,
   output logic                  o_busy
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ID_W-1:0]   r_ptr;
   logic [ID_W-1:0]   r_gnt_id;
   logic [2:0]        r_alu_op;
   logic              r_alu_immd_sel;
   logic [ALU_W-1:0]  r_alu_reg1;
   logic [ALU_W-1:0]  r_alu_reg2;
   logic [IMM_W-1:0]  r_alu_immd;
   logic [ALU_W-1:0]  r_rsp_data;

   logic [NREQ-1:0]   w_pick_valid;
   logic [NREQ-1:0]   w_rr_gnt;
   logic [ID_W-1:0]   w_rr_idx;
   logic [NREQ-1:0]   w_gnt;
   logic [ID_W-1:0]   w_idx;
   logic [ID_W-1:0]   w_ptr_nxt;
   logic              w_accept;
   logic              w_rsp_hs;
   logic [2:0]        w_op;
   logic              w_sel;
   logic [ALU_W-1:0]  w_reg1;
   logic [ALU_W-1:0]  w_reg2;
   logic [IMM_W-1:0]  w_immd;

   alu_rr_pick #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_pick (
      .i_valid (w_pick_valid),
      .i_ptr   (r_ptr),
      .o_gnt   (w_rr_gnt),
      .o_idx   (w_rr_idx)
   );

`ifdef ALU_ARB_PRIO_EN
   // Requester 0 bypasses the ring; the ring only ever sees indices 1..NREQ-1.
   assign w_pick_valid = i_req_valid & ~NREQ'(1);
   assign w_gnt        = i_req_valid[0] ? NREQ'(1) : w_rr_gnt;
   assign w_idx        = i_req_valid[0] ? '0 : w_rr_idx;
   // A priority grant leaves the ring position alone; the ring wraps to 1, not 0.
   assign w_ptr_nxt    = (r_gnt_id == '0)              ? r_ptr    :
                         (r_gnt_id == ID_W'(NREQ - 1)) ? ID_W'(1) :
                                                         r_gnt_id + 1'b1;
`else
   assign w_pick_valid = i_req_valid;
   assign w_gnt        = w_rr_gnt;
   assign w_idx        = w_rr_idx;
   assign w_ptr_nxt    = (r_gnt_id == ID_W'(NREQ - 1)) ? '0 : r_gnt_id + 1'b1;
`endif

   // Winner payload mux; only meaningful when w_gnt is non-zero.
   always_comb begin
      w_op   = ADD;
      w_sel  = 1'b0;
      w_reg1 = '0;
      w_reg2 = '0;
      w_immd = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt[i]) begin
            w_op   = i_req_op[3*i +: 3];
            w_sel  = i_req_immd_sel[i];
            w_reg1 = i_req_reg1[ALU_W*i +: ALU_W];
            w_reg2 = i_req_reg2[ALU_W*i +: ALU_W];
            w_immd = i_req_immd[IMM_W*i +: IMM_W];
         end
      end
   end

   // Next state and handshake outputs. Ready is gated by reset so nothing is
   // offered while the block is held in reset.
   always_comb begin
      w_state_nxt = r_state;
      o_req_ready = '0;
      o_rsp_valid = '0;
      o_busy      = (r_state != IDLE);
      w_accept    = 1'b0;
      w_rsp_hs    = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         o_rsp_valid[i] = (r_state == RESP) && (r_gnt_id == ID_W'(i));
      end
      case (r_state)
         IDLE: begin
            o_req_ready = i_rst_n ? w_gnt : '0;
            w_accept    = |o_req_ready;
            w_state_nxt = w_accept ? EXEC : IDLE;
         end
         EXEC: w_state_nxt = RESP;
         RESP: begin
            w_rsp_hs    = |(o_rsp_valid & i_rsp_ready);
            w_state_nxt = w_rsp_hs ? IDLE : RESP;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= IDLE;
         r_ptr          <= '0;
         r_gnt_id       <= '0;
         r_alu_op       <= ADD;
         r_alu_immd_sel <= 1'b0;
         r_alu_reg1     <= '0;
         r_alu_reg2     <= '0;
         r_alu_immd     <= '0;
         r_rsp_data     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_gnt_id       <= w_idx;
            r_alu_op       <= w_op;
            r_alu_immd_sel <= w_sel;
            r_alu_reg1     <= w_reg1;
            r_alu_reg2     <= w_reg2;
            r_alu_immd     <= w_immd;
         end
         if (r_state == EXEC) r_rsp_data <= i_alu_data_out;
         if (w_rsp_hs) r_ptr <= w_ptr_nxt;
      end
   end

   assign o_alu_op       = r_alu_op;
   assign o_alu_immd_sel = r_alu_immd_sel;
   assign o_alu_reg1     = r_alu_reg1;
   assign o_alu_reg2     = r_alu_reg2;
   assign o_alu_immd     = r_alu_immd;
   assign o_rsp_data     = r_rsp_data;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks of alu_arbiter against a transaction-level model.
module tb_alu_arbiter;

   localparam int N  = 3;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [3*N-1:0]  req_op = '0;
   logic [N-1:0]    req_sel = '0;
   logic [32*N-1:0] req_r1 = '0;
   logic [32*N-1:0] req_r2 = '0;
   logic [17*N-1:0] req_im = '0;
   logic [2:0]      alu_op;
   logic            alu_sel;
   logic [31:0]     alu_r1, alu_r2, alu_out, rsp_data;
   logic [16:0]     alu_im;
   logic [N-1:0]    rsp_valid;
   logic [N-1:0]    rsp_ready = '0;
   logic            busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.NREQ(N), .ID_W(IW)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_req_valid    (req_valid),
      .o_req_ready    (req_ready),
      .i_req_op       (req_op),
      .i_req_immd_sel (req_sel),
      .i_req_reg1     (req_r1),
      .i_req_reg2     (req_r2),
      .i_req_immd     (req_im),
      .o_alu_op       (alu_op),
      .o_alu_immd_sel (alu_sel),
      .o_alu_reg1     (alu_r1),
      .o_alu_reg2     (alu_r2),
      .o_alu_immd     (alu_im),
      .i_alu_data_out (alu_out),
      .o_rsp_valid    (rsp_valid),
      .o_rsp_data     (rsp_data),
      .i_rsp_ready    (rsp_ready),
      .o_busy         (busy)
   );

   function automatic logic [31:0] alu_f(input logic [2:0] op, input logic sel,
                                         input logic [31:0] a, input logic [31:0] r2,
                                         input logic [16:0] im);
      logic [31:0] b;
      b = sel ? {15'd0, im} : r2;
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return ~(a | b);
         3'd5: return a << b[4:0];
         3'd6: return a >> b[4:0];
         default: return $unsigned($signed(a) >>> b[4:0]);
      endcase
   endfunction

   assign alu_out = alu_f(alu_op, alu_sel, alu_r1, alu_r2, alu_im);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: one outstanding operation, aged in cycles since accept.
   int          m_ptr = 0;
   bit          m_act = 0;
   int          m_age = 0;
   int          m_w = 0;
   int          m_acc = -1;
   logic [2:0]  m_op = 0;
   logic        m_sel = 0;
   logic [31:0] m_r1 = 0, m_r2 = 0, m_res = 0;
   logic [16:0] m_im = 0;

   function automatic int pick_win();
`ifdef ALU_ARB_PRIO_EN
      if (req_valid[0]) return 0;
`endif
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_ptr + k) % N;
`ifdef ALU_ARB_PRIO_EN
         if (j == 0) continue;
`endif
         if (req_valid[j]) return j;
      end
      return -1;
   endfunction

   // Called right after a falling edge with inputs driven: checks this cycle, then
   // advances the model across the coming rising edge.
   task automatic cyc();
      logic [N-1:0] e_rr, e_rv;
      logic         e_busy;
      int           w;
      #1;
      e_rr = '0; e_rv = '0; e_busy = 1'b0; w = -1; m_acc = -1;
      if (!rst_n) begin
         m_act = 0; m_ptr = 0; m_op = 0; m_sel = 0; m_r1 = 0; m_r2 = 0; m_im = 0; m_res = 0;
      end else if (!m_act) begin
         w = pick_win();
         if (w >= 0) e_rr[w] = 1'b1;
      end else begin
         e_busy = 1'b1;
         if (m_age >= 2) e_rv[m_w] = 1'b1;
      end
      chk("req_ready", req_ready, e_rr);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("busy", busy, e_busy);
      chk("alu_op", alu_op, m_op);
      chk("alu_immd_sel", alu_sel, m_sel);
      chk("alu_reg1", alu_r1, m_r1);
      chk("alu_reg2", alu_r2, m_r2);
      chk("alu_immd", alu_im, m_im);
      chk("rsp_data", rsp_data, m_res);
      if (rst_n) begin
         if (!m_act && w >= 0) begin
            m_act = 1; m_age = 1; m_w = w; m_acc = w;
            m_op = req_op[3*w +: 3]; m_sel = req_sel[w];
            m_r1 = req_r1[32*w +: 32]; m_r2 = req_r2[32*w +: 32]; m_im = req_im[17*w +: 17];
         end else if (m_act && m_age == 1) begin
            m_res = alu_f(m_op, m_sel, m_r1, m_r2, m_im);
            m_age = 2;
         end else if (m_act && rsp_ready[m_w]) begin
            m_act = 0;
`ifdef ALU_ARB_PRIO_EN
            if (m_w != 0) m_ptr = (m_w == N - 1) ? 1 : m_w + 1;
`else
            m_ptr = (m_w + 1) % N;
`endif
         end
      end
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic sel,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [16:0] im);
      req_valid[i]      = 1'b1;
      req_op[3*i +: 3]  = op;
      req_sel[i]        = sel;
      req_r1[32*i +: 32] = r1;
      req_r2[32*i +: 32] = r2;
      req_im[17*i +: 17] = im;
   endtask

   task automatic drain();
      req_valid = '0;
      rsp_ready = '1;
      repeat (4) begin
         cyc();
         @(negedge clk);
      end
      rsp_ready = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int g[8];
      int gc[8];
      int ng;
      int drop;
      repeat (2) @(negedge clk);
      // Reset: nothing is offered even with requests pending.
      req_valid = 3'b011;
      cyc();
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", req_ready, 3'b000);
      chk("rst_alu_op", alu_op, 3'd0);
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = '0;
      // Single ADD from requester 0.
      set_req(0, 3'd0, 1'b0, 32'd5, 32'd7, 17'd0);
      cyc();
      chk("t1_ready", req_ready, 3'b001);
      @(negedge clk);
      req_valid = '0;
      cyc();
      chk("t1_reg1", alu_r1, 32'd5);
      chk("t1_reg2", alu_r2, 32'd7);
      chk("t1_busy", busy, 1'b1);
      @(negedge clk);
      rsp_ready = 3'b001;
      cyc();
      chk("t1_rsp_valid", rsp_valid, 3'b001);
      chk("t1_rsp_data", rsp_data, 32'd12);
      @(negedge clk);
      rsp_ready = '0;
      cyc();
      chk("t1_idle", busy, 1'b0);
      @(negedge clk);
      // Immediate path from requester 1.
      set_req(1, 3'd3, 1'b1, 32'hF0, 32'h0, 17'h0F);
      cyc();
      chk("t2_ready", req_ready, 3'b010);
      @(negedge clk);
      req_valid = '0;
      cyc();
      chk("t2_immd_sel", alu_sel, 1'b1);
      chk("t2_op", alu_op, 3'd3);
      @(negedge clk);
      rsp_ready = 3'b010;
      cyc();
      chk("t2_rsp_valid", rsp_valid, 3'b010);
      chk("t2_rsp_data", rsp_data, 32'hFF);
      @(negedge clk);
      // Contention between requesters 0 and 1 with responses always accepted.
      set_req(0, 3'd0, 1'b0, 32'd1, 32'd2, 17'd0);
      set_req(1, 3'd1, 1'b0, 32'd9, 32'd4, 17'd0);
      rsp_ready = '1;
      ng = 0;
      for (int c = 0; c < 12; c++) begin
         cyc();
         if (|(req_ready & req_valid) && ng < 8) begin
            g[ng] = req_ready[1] ? 1 : req_ready[2] ? 2 : 0;
            gc[ng] = c;
            ng++;
         end
         @(negedge clk);
      end
      chk("t3_count", ng, 4);
      for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_PRIO_EN
         chk("t3_grant", g[k], 0);
`else
         chk("t3_grant", g[k], k % 2);
`endif
         chk("t3_cycle", gc[k], 3 * k);
      end
      drain();
      // Back-pressure: response held for 5 cycles while others wait.
      set_req(0, 3'd1, 1'b0, 32'd100, 32'd1, 17'd0);
      cyc();
      chk("t4_ready", req_ready, 3'b001);
      @(negedge clk);
      req_valid = '0;
      set_req(1, 3'd2, 1'b0, 32'hFF00, 32'h0FF0, 17'd0);
      set_req(2, 3'd4, 1'b0, 32'h1, 32'h2, 17'd0);
      cyc();
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         cyc();
         chk("t4_hold_valid", rsp_valid, 3'b001);
         chk("t4_hold_data", rsp_data, 32'd99);
         chk("t4_no_ready", req_ready, 3'b000);
         @(negedge clk);
      end
      rsp_ready = 3'b001;
      cyc();
      @(negedge clk);
      rsp_ready = '0;
      cyc();
`ifdef ALU_ARB_PRIO_EN
      chk("t4_next", req_ready, 3'b100);
`else
      chk("t4_next", req_ready, 3'b010);
`endif
      @(negedge clk);
      drain();
      // Reset during EXEC discards the operation; ring restarts at 0.
      set_req(1, 3'd7, 1'b0, 32'h8000_0000, 32'd4, 17'd0);
      cyc();
      @(negedge clk);
      set_req(0, 3'd0, 1'b0, 32'd3, 32'd3, 17'd0);
      rst_n = 1'b0;
      cyc();
      chk("t5_busy", busy, 1'b0);
      chk("t5_rsp_valid", rsp_valid, 3'b000);
      chk("t5_alu_op", alu_op, 3'd0);
      chk("t5_rsp_data", rsp_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      chk("t5_first", req_ready, 3'b001);
      @(negedge clk);
      drain();
      // Randomized traffic with occasional resets and drops.
      drop = -1;
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(0, 299) != 0);
         if (drop >= 0) req_valid[drop] = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (req_valid[i]) begin
               if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
               set_req(i, 3'($urandom), 1'($urandom), $urandom, $urandom, 17'($urandom));
            end
         end
         rsp_ready = N'($urandom);
         cyc();
         drop = m_acc;
         @(negedge clk);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
